// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction-memory write port and boot status for imem_loader.
// master = loader side, slave = stream source / memory / CPU side.
interface imem_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    modport master (
        input  byte_valid, byte_data,
        output byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error
    );

    modport slave (
        output byte_valid, byte_data,
        input  byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: 16-bit LE word count, then LE 32-bit words written to instruction memory;
// keeps the CPU held until the load completes, errors are sticky until reset.
//
// state | meaning
// LEN0  | waiting for word-count low byte (no timeout)
// LEN1  | waiting for word-count high byte, length checked on arrival
// DATA  | collecting the 4 bytes of the current word
// WRITE | one-cycle memory write of the assembled word
// DONE  | load complete, CPU released, stream ignored
// ERR   | bad length or stalled stream, CPU held
module imem_loader #(
    parameter logic [63:0] BASE_ADDR      = 64'd0,
    parameter int          DEPTH_WORDS    = 256,
    parameter int          TIMEOUT_CYCLES = 1000
) (
    input  logic         clk,
    input  logic         reset,
    imem_loader_if.master bus
);
    typedef enum logic [2:0] {
        S_LEN0, S_LEN1, S_DATA, S_WRITE, S_DONE, S_ERR
    } state_t;

    localparam int              TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]     DEPTH_L  = 17'(DEPTH_WORDS);

    state_t        state, state_next;
    logic [15:0]   n_words;
    logic [15:0]   word_idx;
    logic [1:0]    byte_idx;
    logic [23:0]   word_buf;
    logic [63:0]   mem_addr_q;
    logic [31:0]   mem_wdata_q;
    logic [TW-1:0] tmo_cnt;

    logic accept, xfer, tmo_hit, len_bad;
    logic mem_we_c, cpu_hold_c, done_c, error_c;

    assign accept  = (state == S_LEN0) || (state == S_LEN1) || (state == S_DATA);
    assign xfer    = bus.byte_valid & accept;
    assign tmo_hit = (tmo_cnt == TMO_LAST);
    assign len_bad = ({bus.byte_data, n_words[7:0]} == 16'd0) ||
                     ({1'b0, bus.byte_data, n_words[7:0]} > DEPTH_L);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_LEN0;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        mem_we_c   = 1'b0;
        cpu_hold_c = 1'b1;
        done_c     = 1'b0;
        error_c    = 1'b0;
        case (state)
            S_LEN0: if (xfer) state_next = S_LEN1;
            S_LEN1: begin
                if (xfer)         state_next = len_bad ? S_ERR : S_DATA;
                else if (tmo_hit) state_next = S_ERR;
            end
            S_DATA: begin
                if (xfer) begin
                    if (byte_idx == 2'd3) state_next = S_WRITE;
                end else if (tmo_hit) begin
                    state_next = S_ERR;
                end
            end
            S_WRITE: begin
                mem_we_c   = 1'b1;
                state_next = (word_idx + 16'd1 == n_words) ? S_DONE : S_DATA;
            end
            S_DONE: begin
                cpu_hold_c = 1'b0;
                done_c     = 1'b1;
            end
            S_ERR:   error_c = 1'b1;
            default: state_next = S_ERR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_words     <= '0;
            word_idx    <= '0;
            byte_idx    <= '0;
            word_buf    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            tmo_cnt     <= '0;
        end else begin
            case (state)
                S_LEN0: begin
                    tmo_cnt <= '0;
                    if (xfer) n_words[7:0] <= bus.byte_data;
                end
                S_LEN1: begin
                    if (xfer) begin
                        n_words[15:8] <= bus.byte_data;
                        tmo_cnt       <= '0;
                    end else if (!tmo_hit) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        tmo_cnt  <= '0;
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: word_buf[7:0]   <= bus.byte_data;
                            2'd1: word_buf[15:8]  <= bus.byte_data;
                            2'd2: word_buf[23:16] <= bus.byte_data;
                            default: begin
                                // Address/data are latched here so they are stable through WRITE.
                                mem_addr_q  <= BASE_ADDR + {46'd0, word_idx, 2'b00};
                                mem_wdata_q <= {bus.byte_data, word_buf};
                            end
                        endcase
                    end else if (!tmo_hit) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_WRITE: begin
                    word_idx <= word_idx + 16'd1;
                    tmo_cnt  <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.byte_ready = accept;
    assign bus.mem_we     = mem_we_c;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.cpu_hold   = cpu_hold_c;
    assign bus.done       = done_c;
    assign bus.error      = error_c;
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (base 0 and base 0x1000) share one byte stream;
// expected writes are queued by the stimulus and popped by per-instance monitors.
module tb_imem_loader;
    typedef struct packed {
        logic [63:0] addr;
        logic [31:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = 8'h00;
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         last_we_a = -10, last_we_b = -10;
    logic       hold_prev_a = 1'b1, hold_prev_b = 1'b1;
    wr_t        exp_a[$];
    wr_t        exp_b[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    imem_loader_if if_a();
    imem_loader_if if_b();
    assign if_a.byte_valid = byte_valid;
    assign if_a.byte_data  = byte_data;
    assign if_b.byte_valid = byte_valid;
    assign if_b.byte_data  = byte_data;

    imem_loader #(.BASE_ADDR(64'h0), .DEPTH_WORDS(256), .TIMEOUT_CYCLES(8))
        dut_a (.clk(clk), .reset(rst), .bus(if_a.master));
    imem_loader #(.BASE_ADDR(64'h1000), .DEPTH_WORDS(256), .TIMEOUT_CYCLES(8))
        dut_b (.clk(clk), .reset(rst), .bus(if_b.master));

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Write monitors: every mem_we must match the head of the scoreboard queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (if_a.mem_we) begin
                checks++;
                last_we_a = cyc;
                if (exp_a.size() == 0) begin
                    failures++;
                    $display("FAIL wr_a unexpected write addr=%0h data=%0h", if_a.mem_addr, if_a.mem_wdata);
                end else begin
                    wr_t e;
                    e = exp_a.pop_front();
                    if ({if_a.mem_addr, if_a.mem_wdata} !== e) begin
                        failures++;
                        $display("FAIL wr_a actual=%0h/%0h required=%0h/%0h",
                                 if_a.mem_addr, if_a.mem_wdata, e.addr, e.data);
                    end
                end
            end
            if (hold_prev_a && !if_a.cpu_hold) chk("hold_fall_a", 128'(cyc), 128'(last_we_a + 1));
        end
        hold_prev_a = if_a.cpu_hold;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (if_b.mem_we) begin
                checks++;
                last_we_b = cyc;
                if (exp_b.size() == 0) begin
                    failures++;
                    $display("FAIL wr_b unexpected write addr=%0h data=%0h", if_b.mem_addr, if_b.mem_wdata);
                end else begin
                    wr_t e;
                    e = exp_b.pop_front();
                    if ({if_b.mem_addr, if_b.mem_wdata} !== e) begin
                        failures++;
                        $display("FAIL wr_b actual=%0h/%0h required=%0h/%0h",
                                 if_b.mem_addr, if_b.mem_wdata, e.addr, e.data);
                    end
                end
            end
            if (hold_prev_b && !if_b.cpu_hold) chk("hold_fall_b", 128'(cyc), 128'(last_we_b + 1));
        end
        hold_prev_b = if_b.cpu_hold;
    end

    task automatic push_wr(input int idx, input logic [31:0] data);
        wr_t e;
        e.addr = 64'(idx * 4);
        e.data = data;
        exp_a.push_back(e);
        e.addr = 64'h1000 + 64'(idx * 4);
        exp_b.push_back(e);
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        @(negedge clk);
        while (!if_a.byte_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!if_a.byte_ready) begin
            checks++;
            failures++;
            $display("FAIL send_wait byte=%0h actual=not_ready required=ready", b);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        byte_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_stream(input logic [7:0] bs[$], input int gap);
        foreach (bs[i]) begin
            send(bs[i]);
            if (gap > 0) idle(gap);
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        send(w[7:0]);
        send(w[15:8]);
        send(w[23:16]);
        send(w[31:24]);
    endtask

    // {byte_ready, cpu_hold, done, error} on both instances
    task automatic chk_status(input string name, input logic r, input logic h, input logic d, input logic e);
        chk({name, "_a"}, {if_a.byte_ready, if_a.cpu_hold, if_a.done, if_a.error}, {r, h, d, e});
        chk({name, "_b"}, {if_b.byte_ready, if_b.cpu_hold, if_b.done, if_b.error}, {r, h, d, e});
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_a"}, {if_a.byte_ready, if_a.mem_we, if_a.mem_addr, if_a.mem_wdata,
                           if_a.cpu_hold, if_a.done, if_a.error},
            {1'b1, 1'b0, 64'd0, 32'd0, 1'b1, 1'b0, 1'b0});
        chk({name, "_b"}, {if_b.byte_ready, if_b.mem_we, if_b.mem_addr, if_b.mem_wdata,
                           if_b.cpu_hold, if_b.done, if_b.error},
            {1'b1, 1'b0, 64'd0, 32'd0, 1'b1, 1'b0, 1'b0});
    endtask

    task automatic do_reset(input string name);
        chk({name, "_pending_a"}, 128'(exp_a.size()), 128'd0);
        chk({name, "_pending_b"}, 128'(exp_b.size()), 128'd0);
        exp_a.delete();
        exp_b.delete();
        byte_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_vals({name, "_rst"});
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;

        // Normal two-word load, valid held high
        do_reset("start");
        push_wr(0, 32'h00A00513);
        push_wr(1, 32'h00100593);
        send_stream('{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00}, 0);
        idle(2);
        chk_status("normal_done", 1'b0, 1'b0, 1'b1, 1'b0);
        byte_valid = 1'b1;
        byte_data  = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        chk_status("done_ignore", 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1);

        // Zero length
        do_reset("zero");
        send_stream('{8'h00, 8'h00}, 0);
        chk_status("zero_err", 1'b0, 1'b1, 1'b0, 1'b1);
        byte_valid = 1'b1;
        byte_data  = 8'h13;
        repeat (3) @(posedge clk);
        #1;
        chk_status("zero_hold", 1'b0, 1'b1, 1'b0, 1'b1);
        idle(1);

        // Oversize N=257, then N=256 full-depth load
        do_reset("n257");
        send_stream('{8'h01, 8'h01}, 0);
        chk_status("n257_err", 1'b0, 1'b1, 1'b0, 1'b1);
        do_reset("n256");
        send_stream('{8'h00, 8'h01}, 0);
        chk_status("n256_data", 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 256; i++) begin
            w = {8'(i), 8'hC3, ~8'(i), 8'h5A};
            push_wr(i, w);
            send_word(w);
        end
        idle(2);
        chk_status("n256_done", 1'b0, 1'b0, 1'b1, 1'b0);

        // Gapped one-word load
        do_reset("gap");
        push_wr(0, 32'hDEADBEEF);
        send_stream('{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE}, 3);
        chk_status("gap_done", 1'b0, 1'b0, 1'b1, 1'b0);

        // Timeout: 7 stalled cycles are tolerated, the 8th errors
        do_reset("tmo");
        send_stream('{8'h01, 8'h00, 8'hEF}, 0);
        idle(7);
        chk_status("tmo_7", 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1);
        chk_status("tmo_8", 1'b0, 1'b1, 1'b0, 1'b1);

        // Byte arriving on the 8th stalled cycle rescues the load
        do_reset("rescue");
        push_wr(0, 32'hDEADBEEF);
        send_stream('{8'h01, 8'h00, 8'hEF}, 0);
        idle(7);
        send(8'hBE);
        chk_status("tmo_rescue", 1'b1, 1'b1, 1'b0, 1'b0);
        send_stream('{8'hAD, 8'hDE}, 0);
        idle(2);
        chk_status("rescue_done", 1'b0, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset after two data bytes, then a clean reload
        do_reset("mid");
        send_stream('{8'h01, 8'h00, 8'hAA, 8'hBB}, 0);
        byte_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("async_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        push_wr(0, 32'h11223344);
        send_stream('{8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11}, 0);
        idle(2);
        chk_status("reload_done", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("end_pending_a", 128'(exp_a.size()), 128'd0);
        chk("end_pending_b", 128'(exp_b.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
